// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl
//   Sequences the alien formation's march. Divides the per-frame tick down to
//   a move cadence of (MIN_PERIOD + alive_count) frames, issues a one-cycle
//   mueva strobe with every move, bounces the formation off the side walls
//   (drop one row, reverse direction) and latches landed once the formation
//   top edge reaches Y_LIMIT.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   frame_tick   one-cycle pulse per video frame
//   enable       1 = march runs, 0 = pause (state held)
//   alive_count  aliens alive, 0..55 (0 = wave cleared, march stops)
//   mueva        one-cycle strobe, coincident with the first cycle of a new position
//   posxE1       formation left-edge x
//   posy         formation top-edge y
//   dir          1 = moving right, 0 = moving left
//   landed       sticky, formation reached Y_LIMIT
module invader_march_ctrl #(
  parameter int unsigned STEP_X     = 8,
  parameter int unsigned STEP_Y     = 16,
  parameter int unsigned X_LEFT     = 16,
  parameter int unsigned X_RIGHT    = 560,
  parameter int unsigned Y_START    = 64,
  parameter int unsigned Y_LIMIT    = 400,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [5:0]  alive_count,
  output logic        mueva,
  output logic [10:0] posxE1,
  output logic [10:0] posy,
  output logic        dir,
  output logic        landed
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STEP_H,
    ST_STEP_V,
    ST_LANDED
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  frame_cnt_q, frame_cnt_d;
  logic [10:0] posx_q, posx_d;
  logic [10:0] posy_q, posy_d;
  logic        dir_q, dir_d;
  logic        mueva_q, mueva_d;
  logic        landed_q, landed_d;

  logic [6:0]  period;
  logic [6:0]  period_m1;
  logic [11:0] posx_ext;
  logic [11:0] posy_next_ext;
  logic        at_wall;

  // 7 bits hold 2 + 55 without overflow; MIN_PERIOD >= 1 keeps period_m1 >= 0.
  assign period    = 7'(alive_count) + 7'(MIN_PERIOD);
  assign period_m1 = period - 7'd1;

  // Wall tests done one bit wider than the position so neither side can wrap.
  assign posx_ext      = {1'b0, posx_q};
  assign posy_next_ext = {1'b0, posy_q} + 12'(STEP_Y);
  assign at_wall = dir_q ? (posx_ext + 12'(STEP_X) > 12'(X_RIGHT))
                         : (posx_ext < 12'(X_LEFT) + 12'(STEP_X));

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    posx_d      = posx_q;
    posy_d      = posy_q;
    dir_d       = dir_q;
    mueva_d     = 1'b0;
    landed_d    = landed_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (frame_tick && enable && (alive_count != '0)) begin
          // >= rather than == so a period that shrank below the count still fires.
          if (frame_cnt_q >= period_m1) begin
            frame_cnt_d = '0;
            state_d     = at_wall ? ST_STEP_V : ST_STEP_H;
          end else begin
            frame_cnt_d = frame_cnt_q + 7'd1;
          end
        end
      end
      ST_STEP_H: begin
        posx_d  = dir_q ? (posx_q + 11'(STEP_X)) : (posx_q - 11'(STEP_X));
        mueva_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_STEP_V: begin
        posy_d  = posy_next_ext[10:0];
        dir_d   = ~dir_q;
        mueva_d = 1'b1;
        if (posy_next_ext >= 12'(Y_LIMIT)) begin
          landed_d = 1'b1;
          state_d  = ST_LANDED;
        end else begin
          state_d  = ST_WAIT;
        end
      end
      ST_LANDED: begin
        landed_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      posx_q      <= 11'(X_LEFT);
      posy_q      <= 11'(Y_START);
      dir_q       <= 1'b1;
      mueva_q     <= 1'b0;
      landed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      posx_q      <= posx_d;
      posy_q      <= posy_d;
      dir_q       <= dir_d;
      mueva_q     <= mueva_d;
      landed_q    <= landed_d;
    end
  end

  assign mueva  = mueva_q;
  assign posxE1 = posx_q;
  assign posy   = posy_q;
  assign dir    = dir_q;
  assign landed = landed_q;

endmodule

// File: tb/tb_invader_march_ctrl.sv
// tb_invader_march_ctrl
//   Self-checking bench for invader_march_ctrl: a fixed vector table, directed
//   multi-cycle sequences (cadence, wall bounces, speed-up, clear, landing) and
//   a randomized run, all checked against an event-level reference model.
module tb_invader_march_ctrl;

  localparam int SX = 8, SY = 16, XL = 16, XR = 560, Y0 = 64, YL = 400, MP = 2;

  logic        clk = 1'b0;
  logic        reset, frame_tick, enable;
  logic [5:0]  alive_count;
  logic        mueva, dir, landed;
  logic [10:0] posxE1, posy;

  int n_vec = 0;
  int n_err = 0;

  invader_march_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .alive_count (alive_count),
    .mueva       (mueva),
    .posxE1      (posxE1),
    .posy        (posy),
    .dir         (dir),
    .landed      (landed)
  );

  always #5 clk = ~clk;

  // Reference model: counts qualifying frame ticks; the period-th one schedules
  // a move (bounce if stepping would leave the wall limits) that becomes visible
  // one edge later. Ticks arriving while a move is in flight are not counted.
  bit m_started, m_dir, m_landed, m_mueva;
  int m_cnt, m_x, m_y, m_pend;

  task automatic model_edge(input bit r, input bit t, input bit e, input int a);
    if (r) begin
      m_started = 0; m_cnt = 0; m_x = XL; m_y = Y0; m_dir = 1;
      m_landed = 0; m_mueva = 0; m_pend = 0;
    end else begin
      m_mueva = 0;
      if (m_landed) begin
      end else if (m_pend == 1) begin
        m_x = m_dir ? m_x + SX : m_x - SX;
        m_mueva = 1; m_pend = 0;
      end else if (m_pend == 2) begin
        m_y = m_y + SY; m_dir = !m_dir; m_mueva = 1; m_pend = 0;
        if (m_y >= YL) m_landed = 1;
      end else if (!m_started) begin
        if (e) m_started = 1;
      end else if (t && e && a != 0) begin
        m_cnt++;
        if (m_cnt >= MP + a) begin
          m_cnt = 0;
          m_pend = ((m_dir && m_x + SX > XR) || (!m_dir && m_x - SX < XL)) ? 2 : 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int em, input int ex,
                         input int ey, input int ed, input int el);
    n_vec++;
    if (int'(mueva) != em || int'(posxE1) != ex || int'(posy) != ey ||
        int'(dir) != ed || int'(landed) != el) begin
      n_err++;
      $display("FAIL %s: got mueva=%0d x=%0d y=%0d dir=%0d landed=%0d, expected mueva=%0d x=%0d y=%0d dir=%0d landed=%0d",
               name, mueva, posxE1, posy, dir, landed, em, ex, ey, ed, el);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare #1 later.
  task automatic cyc(input bit r, input bit t, input bit e, input int a);
    reset = r; frame_tick = t; enable = e; alive_count = 6'(a);
    @(posedge clk);
    model_edge(r, t, e, a);
    #1;
    chk_all("model", int'(m_mueva), m_x, m_y, int'(m_dir), int'(m_landed));
  endtask

  // Tick every cycle (alive=1, period 3) until a move appears, bounded.
  task automatic move_once();
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, 1, 1);
      if (mueva) return;
    end
    chk("move_timeout", 0, 1);
  endtask

  typedef struct {
    bit r, t, e; int a;
    int m, x, y, d, l;
  } vec_t;
  vec_t tbl[21];

  int cnt_m;
  int saved_y, saved_x;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //           r t e  a   m   x   y  d l
    tbl[0]  = '{1,0,0, 0,  0, 16, 64, 1,0};   // reset
    tbl[1]  = '{0,0,1, 0,  0, 16, 64, 1,0};   // IDLE -> WAIT
    tbl[2]  = '{0,1,1, 0,  0, 16, 64, 1,0};   // alive 0: hold
    tbl[3]  = '{0,1,1, 1,  0, 16, 64, 1,0};   // cnt 1
    tbl[4]  = '{0,1,1, 1,  0, 16, 64, 1,0};   // cnt 2
    tbl[5]  = '{0,1,1, 1,  0, 16, 64, 1,0};   // period reached -> step
    tbl[6]  = '{0,1,1, 1,  1, 24, 64, 1,0};   // mueva, tick ignored
    tbl[7]  = '{0,1,1, 1,  0, 24, 64, 1,0};   // cnt 1
    tbl[8]  = '{0,1,1, 1,  0, 24, 64, 1,0};   // cnt 2
    tbl[9]  = '{0,0,0, 1,  0, 24, 64, 1,0};   // paused
    tbl[10] = '{0,1,0, 1,  0, 24, 64, 1,0};   // paused tick not counted
    tbl[11] = '{0,1,1, 1,  0, 24, 64, 1,0};   // resumes from held count -> step
    tbl[12] = '{0,0,0, 1,  1, 32, 64, 1,0};   // enable drop does not abort
    tbl[13] = '{0,1,1, 0,  0, 32, 64, 1,0};   // cleared wave: hold
    tbl[14] = '{1,1,1, 1,  0, 16, 64, 1,0};   // reset beats tick
    tbl[15] = '{0,0,1, 1,  0, 16, 64, 1,0};
    tbl[16] = '{0,1,1, 1,  0, 16, 64, 1,0};
    tbl[17] = '{0,1,1, 1,  0, 16, 64, 1,0};
    tbl[18] = '{0,1,1, 1,  0, 16, 64, 1,0};   // in STEP_H after this edge
    tbl[19] = '{1,1,1, 1,  0, 16, 64, 1,0};   // reset during STEP_H: no mueva
    tbl[20] = '{0,1,0, 1,  0, 16, 64, 1,0};   // back in IDLE

    reset = 1; frame_tick = 0; enable = 0; alive_count = '0;
    model_edge(1, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].t, tbl[i].e, tbl[i].a);
      chk_all($sformatf("table[%0d]", i), tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].l);
    end

    // Reset with enable low: ticks never start the march.
    cyc(1, 0, 0, 3);
    cnt_m = 0;
    for (int i = 0; i < 100; i++) begin cyc(0, 1, 0, 3); cnt_m += int'(mueva); end
    chk("idle_no_mueva", cnt_m, 0);
    chk("idle_x", int'(posxE1), 16);

    // Cadence: period 5, 20 spaced ticks, moves one cycle after every 5th.
    cyc(1, 0, 0, 3);
    cyc(0, 0, 1, 3);
    cnt_m = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 1, 1, 3);
      cyc(0, 0, 1, 3);
      chk($sformatf("cadence_mueva_%0d", i), int'(mueva), (i % 5 == 0) ? 1 : 0);
      if (mueva) begin
        cnt_m++;
        chk($sformatf("cadence_x_%0d", i), int'(posxE1), 16 + 8 * cnt_m);
      end
      cyc(0, 0, 1, 3);
      chk("cadence_width", int'(mueva), 0);
    end
    chk("cadence_count", cnt_m, 4);

    // Right wall: march to 560, bounce, then step left.
    cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 100 && !(posxE1 == 11'd560 && dir); i++) move_once();
    chk("reach_right", int'(posxE1), 560);
    move_once();
    chk_all("right_bounce", 1, 560, 80, 0, 0);
    move_once();
    chk("after_right", int'(posxE1), 552);

    // Left wall: march to 16, bounce, then step right.
    for (int i = 0; i < 100 && !(posxE1 == 11'd16 && !dir); i++) move_once();
    chk("reach_left", int'(posxE1), 16);
    saved_y = int'(posy);
    move_once();
    chk_all("left_bounce", 1, 16, saved_y + 16, 1, 0);
    move_once();
    chk("after_left", int'(posxE1), 24);

    // Speed-up: count 7 at period 12, then alive drops to 1.
    cyc(1, 0, 0, 10);
    cyc(0, 0, 1, 10);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 10);
    chk("speedup_quiet", int'(posxE1), 16);
    cyc(0, 1, 1, 1);
    cyc(0, 0, 1, 1);
    chk("speedup_move", int'(mueva), 1);
    chk("speedup_x", int'(posxE1), 24);

    // Clear: alive 10 -> 0 stops the march.
    cyc(1, 0, 0, 10);
    cyc(0, 0, 1, 10);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 10);
    cnt_m = 0;
    for (int i = 0; i < 60; i++) begin cyc(0, 1, 1, 0); cnt_m += int'(mueva); end
    chk("clear_no_mueva", cnt_m, 0);

    // Landing: march until landed, then everything frozen.
    cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    for (int i = 0; i < 30000 && !landed; i++) cyc(0, 1, 1, 1);
    chk("landed_flag", int'(landed), 1);
    chk("landed_y", int'(posy), 400);
    saved_x = int'(posxE1);
    cnt_m = 0;
    for (int i = 0; i < 20; i++) begin cyc(0, 1, 1, 1); cnt_m += int'(mueva); end
    chk("landed_no_mueva", cnt_m, 0);
    chk("landed_x_frozen", int'(posxE1), saved_x);
    chk("landed_y_frozen", int'(posy), 400);
    cyc(1, 1, 1, 1);
    chk_all("landed_reset", 0, 16, 64, 1, 0);

    // Randomized run against the model.
    for (int i = 0; i < 4000; i++) begin
      bit r, t, e;
      int a;
      r = ($urandom_range(0, 499) == 0);
      t = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 9) != 0);
      a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 55)) : int'($urandom_range(0, 3));
      cyc(r, t, e, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
